store_queue_ring: RTL and testbench
===================================

STORE_QUEUE_RING -- requirements
Module: store_queue_ring

Interface
REQ-001 Parameter NUM_ENTRIES, default 16: queue depth; power of two, 4..64.
REQ-002 Parameter NUM_LD_PORTS, default 2: independent load-forwarding ports.
REQ-003 Parameter SQN_W, default 7: store sequence number width; 2^SQN_W >= 2*NUM_ENTRIES.
REQ-004 Clock is clk and reset is rst; reset is asynchronous and active-high; there is one clock.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 IN_st_valid  in  1  store enqueue strobe.
REQ-008 IN_st_sqN  in  SQN_W  store sequence number.
REQ-009 IN_st_addr  in  30  word address.
REQ-010 IN_st_data  in  32  store data.
REQ-011 IN_st_wmask  in  4  byte mask.
REQ-012 IN_curSqN  in  SQN_W  commit pointer: stores with sqN older than this are committed.
REQ-013 IN_flush_valid  in  1  mispredict flush.
REQ-014 IN_flush_sqN  in  SQN_W  last surviving sqN.
REQ-015 IN_ld_valid  in  NUM_LD_PORTS  load lookup strobes.
REQ-016 IN_ld_addr  in  NUM_LD_PORTS*30  load word addresses.
REQ-017 IN_ld_sqN  in  NUM_LD_PORTS*SQN_W  load sqN; stores strictly older than this sqN forward.
REQ-018 OUT_fwd_valid  out  NUM_LD_PORTS  forward result strobe.
REQ-019 OUT_fwd_data  out  NUM_LD_PORTS*32  forwarded bytes.
REQ-020 OUT_fwd_mask  out  NUM_LD_PORTS*4  forwarded byte mask.
REQ-021 OUT_mem_valid  out  1  drain request.
REQ-022 OUT_mem_addr  out  30  drain address.
REQ-023 OUT_mem_data  out  32  drain data.
REQ-024 OUT_mem_wmask  out  4  drain byte mask.
REQ-025 IN_mem_ready  in  1  drain accept.
REQ-026 OUT_maxStoreSqN  out  SQN_W  youngest sqN allowed to enqueue.
REQ-027 OUT_empty  out  1  no valid entries.

Function
REQ-028 Storage is a circular buffer; the slot is IN_st_sqN mod NUM_ENTRIES; there is no shifting.
REQ-029 Age comparisons use the signed difference (a-b) in SQN_W bits.
REQ-030 Enqueue writes the slot as valid and uncommitted; it is dropped if IN_flush_valid is set and IN_st_sqN is younger than IN_flush_sqN.
REQ-031 Each cycle, every valid entry whose sqN is older than IN_curSqN is marked committed; committed is sticky.
REQ-032 On flush, every uncommitted valid entry younger than IN_flush_sqN is invalidated in that cycle; committed entries are never flushed.
REQ-033 OUT_mem_valid is asserted combinationally when the head slot is valid and committed; the address, data and mask come from the head slot.
REQ-034 A pop occurs on OUT_mem_valid && IN_mem_ready: the head slot is invalidated and baseSqN increments, wrapping mod 2^SQN_W.
REQ-035 OUT_mem_valid drain outputs are held stable until accepted.
REQ-036 OUT_maxStoreSqN is registered and equals baseSqN+NUM_ENTRIES-1 (mod 2^SQN_W); enqueue beyond it is illegal and covered by an assertion.
REQ-037 A full queue (NUM_ENTRIES valid) does not block drain, and simultaneous pop+enqueue into the freed slot is legal.
REQ-038 Forwarding has 1-cycle latency: IN_ld_valid in cycle N gives OUT_fwd_* in N+1.
REQ-039 Forward match condition: valid entry, equal address, and entry sqN older than IN_ld_sqN.
REQ-040 Per byte, the youngest matching store wins.
REQ-041 OUT_fwd_mask is the OR of the matching masks, and unmasked data bytes are 0.
REQ-042 A lookup in cycle N sees state before cycle-N enqueue, flush and pop (no bypass).
REQ-043 A load whose IN_ld_sqN is flushed in cycle N+1 gets OUT_fwd_valid=0 in that cycle.
REQ-044 OUT_empty equals the NOR of the entry valid bits.

Reset
REQ-045 rst clears all valid and committed bits, baseSqN=0, OUT_fwd_valid=0 and OUT_mem_valid=0.
REQ-046 After rst, OUT_maxStoreSqN=NUM_ENTRIES-1, OUT_empty=1, and OUT_fwd_data/mask=0.
REQ-047 rst asserted mid-drain drops the pending request with no partial pop.

Structure
REQ-048 The package sq_pkg holds the sq_entry_t typedef (valid, committed, sqN, addr, data, wmask) and the age-compare function.
REQ-049 The single sub-module sq_fwd_lookup is instantiated NUM_LD_PORTS times and performs the per-port match and byte merge.

Verification
REQ-050 Test 1: enqueue sqN 0..3, set curSqN=4, hold ready=1 -> four drains in order on consecutive cycles, then OUT_maxStoreSqN=19.
REQ-051 Test 2: store sqN 2 to addr 0x10 with data 0xAABBCCDD and mask 0011, then load sqN 5 to 0x10 -> next cycle mask=0011, data=0x0000CCDD.
REQ-052 Test 3: stores sqN 1 (mask 1111, data 0x11111111) and sqN 3 (mask 0001, data 0x22), then load sqN 4 -> data=0x11111122, mask=1111.
REQ-053 Test 4: entries sqN 0..5 with curSqN=2, then flush with sqN=3 -> sqN 4 and 5 invalid, 0..3 retained, and the drain yields 0 and 1 only.
REQ-054 Test 5: fill all 16 entries with SQN_W wrap (sqN 120..135 mod 128), commit all, hold ready=0 for 5 cycles -> OUT_mem_valid stable; then ready=1 -> 16 pops in order and OUT_empty=1.
REQ-055 Test 6: assert rst while OUT_mem_valid=1 and ready=0 -> OUT_mem_valid=0 immediately and OUT_maxStoreSqN=15.

Source files
------------

// File: rtl/sq_pkg.sv
// Shared types and the wrap-aware age compare used by the store queue.
package sq_pkg;
    // Stored sqN field is wide enough for any legal SQN_W; callers zero-extend
    localparam int SQN_MAX_W = 16;

    typedef struct packed {
        logic                 valid;
        logic                 committed;
        logic [SQN_MAX_W-1:0] sqN;
        logic [29:0]          addr;
        logic [31:0]          data;
        logic [3:0]           wmask;
    } sq_entry_t;

    // a is older than b when (a-b), taken in w bits, is negative
    function automatic logic age_lt(input logic [SQN_MAX_W-1:0] a,
                                    input logic [SQN_MAX_W-1:0] b,
                                    input int w);
        logic [SQN_MAX_W-1:0] d;
        d = a - b;
        return d[w-1];
    endfunction
endpackage

// File: rtl/sq_fwd_lookup.sv
// Per-port store-to-load forwarding: match on address and age, youngest byte wins.
module sq_fwd_lookup
    import sq_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int SQN_W       = 7
) (
    input  sq_entry_t [NUM_ENTRIES-1:0] entries_i,
    input  logic [SQN_W-1:0]            base_sqN_i,
    input  logic [29:0]                 ld_addr_i,
    input  logic [SQN_W-1:0]            ld_sqN_i,
    output logic [31:0]                 data_o,
    output logic [3:0]                  mask_o
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    sq_entry_t        e;
    logic [IDX_W-1:0] slot;

    // Walk slots oldest-to-youngest from the head so later matches overwrite bytes
    always_comb begin
        data_o = '0;
        mask_o = '0;
        e      = '0;
        slot   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            slot = base_sqN_i[IDX_W-1:0] + IDX_W'(i);
            e    = entries_i[slot];
            if (e.valid && e.addr == ld_addr_i &&
                age_lt(e.sqN, SQN_MAX_W'(ld_sqN_i), SQN_W)) begin
                for (int b = 0; b < 4; b++) begin
                    if (e.wmask[b]) data_o[8*b +: 8] = e.data[8*b +: 8];
                end
                mask_o = mask_o | e.wmask;
            end
        end
    end
endmodule

// File: rtl/store_queue_ring.sv
// Circular store queue: slot = sqN mod depth, in-order drain, multi-port forwarding.
module store_queue_ring
    import sq_pkg::*;
#(
    parameter int NUM_ENTRIES  = 16,
    parameter int NUM_LD_PORTS = 2,
    parameter int SQN_W        = 7
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       IN_st_valid,
    input  logic [SQN_W-1:0]           IN_st_sqN,
    input  logic [29:0]                IN_st_addr,
    input  logic [31:0]                IN_st_data,
    input  logic [3:0]                 IN_st_wmask,
    input  logic [SQN_W-1:0]           IN_curSqN,
    input  logic                       IN_flush_valid,
    input  logic [SQN_W-1:0]           IN_flush_sqN,
    input  logic [NUM_LD_PORTS-1:0]    IN_ld_valid,
    input  logic [NUM_LD_PORTS*30-1:0] IN_ld_addr,
    input  logic [NUM_LD_PORTS*SQN_W-1:0] IN_ld_sqN,
    output logic [NUM_LD_PORTS-1:0]    OUT_fwd_valid,
    output logic [NUM_LD_PORTS*32-1:0] OUT_fwd_data,
    output logic [NUM_LD_PORTS*4-1:0]  OUT_fwd_mask,
    output logic                       OUT_mem_valid,
    output logic [29:0]                OUT_mem_addr,
    output logic [31:0]                OUT_mem_data,
    output logic [3:0]                 OUT_mem_wmask,
    input  logic                       IN_mem_ready,
    output logic [SQN_W-1:0]           OUT_maxStoreSqN,
    output logic                       OUT_empty
);
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    sq_entry_t [NUM_ENTRIES-1:0] ent_q, ent_d;
    logic [SQN_W-1:0]            base_q, base_d, max_q;
    logic [IDX_W-1:0]            head, st_slot;
    logic                        pop, st_drop;
    logic [NUM_ENTRIES-1:0]      vld_vec;

    assign head    = base_q[IDX_W-1:0];
    assign st_slot = IN_st_sqN[IDX_W-1:0];
    assign st_drop = IN_flush_valid &&
                     age_lt(SQN_MAX_W'(IN_flush_sqN), SQN_MAX_W'(IN_st_sqN), SQN_W);

    assign OUT_mem_valid   = ent_q[head].valid && ent_q[head].committed;
    assign OUT_mem_addr    = ent_q[head].addr;
    assign OUT_mem_data    = ent_q[head].data;
    assign OUT_mem_wmask   = ent_q[head].wmask;
    assign pop             = OUT_mem_valid && IN_mem_ready;
    assign OUT_maxStoreSqN = max_q;

    // Gather valid bits for the empty flag
    always_comb begin
        vld_vec = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) vld_vec[i] = ent_q[i].valid;
    end
    assign OUT_empty = ~|vld_vec;

    // Next-state: commit, flush, pop, then enqueue (enqueue may reuse the popped slot)
    always_comb begin
        ent_d = ent_q;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_q[i].valid &&
                age_lt(ent_q[i].sqN, SQN_MAX_W'(IN_curSqN), SQN_W))
                ent_d[i].committed = 1'b1;
            if (IN_flush_valid && ent_q[i].valid && !ent_q[i].committed &&
                age_lt(SQN_MAX_W'(IN_flush_sqN), ent_q[i].sqN, SQN_W)) begin
                ent_d[i].valid     = 1'b0;
                ent_d[i].committed = 1'b0;
            end
        end
        if (pop) begin
            ent_d[head].valid     = 1'b0;
            ent_d[head].committed = 1'b0;
        end
        if (IN_st_valid && !st_drop) begin
            ent_d[st_slot].valid     = 1'b1;
            ent_d[st_slot].committed = 1'b0;
            ent_d[st_slot].sqN       = SQN_MAX_W'(IN_st_sqN);
            ent_d[st_slot].addr      = IN_st_addr;
            ent_d[st_slot].data      = IN_st_data;
            ent_d[st_slot].wmask     = IN_st_wmask;
        end
        base_d = base_q + SQN_W'(pop);
    end

    // Queue state and the registered enqueue limit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q  <= '0;
            base_q <= '0;
            max_q  <= SQN_W'(NUM_ENTRIES - 1);
        end else begin
            ent_q  <= ent_d;
            base_q <= base_d;
            max_q  <= base_d + SQN_W'(NUM_ENTRIES - 1);
        end
    end

    logic [NUM_LD_PORTS-1:0] fwd_vld_q;
    logic [SQN_W-1:0]        ld_sqN_q [NUM_LD_PORTS];

    for (genvar p = 0; p < NUM_LD_PORTS; p++) begin : g_ld
        logic [31:0] lk_data;
        logic [3:0]  lk_mask;

        sq_fwd_lookup #(.NUM_ENTRIES(NUM_ENTRIES), .SQN_W(SQN_W)) u_lookup (
            .entries_i (ent_q),
            .base_sqN_i(base_q),
            .ld_addr_i (IN_ld_addr[p*30 +: 30]),
            .ld_sqN_i  (IN_ld_sqN[p*SQN_W +: SQN_W]),
            .data_o    (lk_data),
            .mask_o    (lk_mask)
        );

        // One-cycle forwarding result register, looked up against pre-update state
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                fwd_vld_q[p]            <= 1'b0;
                ld_sqN_q[p]             <= '0;
                OUT_fwd_data[p*32 +: 32] <= '0;
                OUT_fwd_mask[p*4 +: 4]   <= '0;
            end else begin
                fwd_vld_q[p]            <= IN_ld_valid[p];
                ld_sqN_q[p]             <= IN_ld_sqN[p*SQN_W +: SQN_W];
                OUT_fwd_data[p*32 +: 32] <= lk_data;
                OUT_fwd_mask[p*4 +: 4]   <= lk_mask;
            end
        end

        // A load squashed by this cycle's flush must not report a result
        assign OUT_fwd_valid[p] = fwd_vld_q[p] && !(IN_flush_valid &&
            age_lt(SQN_MAX_W'(IN_flush_sqN), SQN_MAX_W'(ld_sqN_q[p]), SQN_W));
    end

    // Enqueue must stay within the window ending at OUT_maxStoreSqN
    a_enq_window: assert property (@(posedge clk) disable iff (rst)
        IN_st_valid |-> !age_lt(SQN_MAX_W'(max_q), SQN_MAX_W'(IN_st_sqN), SQN_W));
endmodule

// File: tb/tb_store_queue_ring.sv
// Directed bench for store_queue_ring with hand-computed expectations.
module tb_store_queue_ring;
    localparam int N = 16, P = 2, W = 7;

    logic            clk = 1'b0, rst = 1'b1;
    logic            st_valid, flush_valid, mem_ready;
    logic [W-1:0]    st_sqN, cur_sqN, flush_sqN;
    logic [29:0]     st_addr;
    logic [31:0]     st_data;
    logic [3:0]      st_wmask;
    logic [P-1:0]    ld_valid;
    logic [P*30-1:0] ld_addr;
    logic [P*W-1:0]  ld_sqN;
    logic [P-1:0]    fwd_valid;
    logic [P*32-1:0] fwd_data;
    logic [P*4-1:0]  fwd_mask;
    logic            mem_valid, empty;
    logic [29:0]     mem_addr;
    logic [31:0]     mem_data;
    logic [3:0]      mem_wmask;
    logic [W-1:0]    max_sqN;

    int checks = 0, errors = 0;

    store_queue_ring #(.NUM_ENTRIES(N), .NUM_LD_PORTS(P), .SQN_W(W)) dut (
        .clk(clk), .rst(rst),
        .IN_st_valid(st_valid), .IN_st_sqN(st_sqN), .IN_st_addr(st_addr),
        .IN_st_data(st_data), .IN_st_wmask(st_wmask), .IN_curSqN(cur_sqN),
        .IN_flush_valid(flush_valid), .IN_flush_sqN(flush_sqN),
        .IN_ld_valid(ld_valid), .IN_ld_addr(ld_addr), .IN_ld_sqN(ld_sqN),
        .OUT_fwd_valid(fwd_valid), .OUT_fwd_data(fwd_data), .OUT_fwd_mask(fwd_mask),
        .OUT_mem_valid(mem_valid), .OUT_mem_addr(mem_addr), .OUT_mem_data(mem_data),
        .OUT_mem_wmask(mem_wmask), .IN_mem_ready(mem_ready),
        .OUT_maxStoreSqN(max_sqN), .OUT_empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        st_valid = 0; st_sqN = '0; st_addr = '0; st_data = '0; st_wmask = '0;
        cur_sqN = '0; flush_valid = 0; flush_sqN = '0; mem_ready = 0;
        ld_valid = '0; ld_addr = '0; ld_sqN = '0;
    endtask

    task automatic do_reset;
        rst = 1; idle(); tick(); tick(); rst = 0;
    endtask

    task automatic st(input int sqn, input logic [29:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        st_valid = 1; st_sqN = W'(sqn); st_addr = a; st_data = d; st_wmask = m;
        tick();
        st_valid = 0;
    endtask

    task automatic ld(input int p, input logic [29:0] a, input int sqn);
        ld_valid[p] = 1'b1;
        ld_addr[p*30 +: 30] = a;
        ld_sqN[p*W +: W] = W'(sqn);
    endtask

    task automatic wait_empty(input string tag);
        int n = 0;
        while (!empty && n < 64) begin tick(); n++; end
        chk(tag, 32'(empty), 32'd1);
    endtask

    initial begin
        idle();
        do_reset();
        // Reset state
        chk("rst_max", 32'(max_sqN), 32'd15);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_memv", 32'(mem_valid), 32'd0);
        chk("rst_fwdv", 32'(fwd_valid), 32'd0);
        chk("rst_fwdd", fwd_data[31:0] | fwd_data[63:32], 32'd0);
        chk("rst_fwdm", 32'(fwd_mask), 32'd0);

        // Test 1: in-order drain on consecutive cycles
        for (int i = 0; i < 4; i++) st(i, 30'h100 + 30'(i), 32'(i), 4'hF);
        cur_sqN = 4; mem_ready = 1;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("t1_memv", 32'(mem_valid), 32'd1);
            chk("t1_addr", 32'(mem_addr), 32'h100 + 32'(k));
            tick();
        end
        chk("t1_max", 32'(max_sqN), 32'd19);
        chk("t1_empty", 32'(empty), 32'd1);

        // Test 2: partial-mask forward, plus an unrelated address on port 1
        do_reset();
        st(2, 30'h10, 32'hAABBCCDD, 4'b0011);
        ld(0, 30'h10, 5); ld(1, 30'h20, 5);
        tick(); ld_valid = '0;
        chk("t2_v0", 32'(fwd_valid[0]), 32'd1);
        chk("t2_m0", 32'(fwd_mask[3:0]), 32'h3);
        chk("t2_d0", fwd_data[31:0], 32'h0000CCDD);
        chk("t2_v1", 32'(fwd_valid[1]), 32'd1);
        chk("t2_m1", 32'(fwd_mask[7:4]), 32'h0);
        chk("t2_d1", fwd_data[63:32], 32'h0);

        // Test 3: youngest byte wins; load sqN 3 must not see store sqN 3
        do_reset();
        st(1, 30'h40, 32'h11111111, 4'b1111);
        st(3, 30'h40, 32'h00000022, 4'b0001);
        ld(0, 30'h40, 3); ld(1, 30'h40, 4);
        tick(); ld_valid = '0;
        chk("t3_d0", fwd_data[31:0], 32'h11111111);
        chk("t3_m0", 32'(fwd_mask[3:0]), 32'hF);
        chk("t3_d1", fwd_data[63:32], 32'h11111122);
        chk("t3_m1", 32'(fwd_mask[7:4]), 32'hF);

        // Test 4: flush keeps committed and older entries
        do_reset();
        for (int i = 0; i < 6; i++) st(i, 30'h100 + 30'(i), 32'(i), 4'hF);
        cur_sqN = 2;
        tick();
        ld(0, 30'h105, 5);
        tick(); ld_valid = '0;
        flush_valid = 1; flush_sqN = 3;
        #1;
        chk("t4_ldsquash", 32'(fwd_valid[0]), 32'd0);
        tick(); flush_valid = 0;
        ld(0, 30'h104, 10); ld(1, 30'h103, 10);
        tick(); ld_valid = '0;
        chk("t4_v0", 32'(fwd_valid[0]), 32'd1);
        chk("t4_gone4", 32'(fwd_mask[3:0]), 32'h0);
        chk("t4_kept3", 32'(fwd_mask[7:4]), 32'hF);
        chk("t4_d3", fwd_data[63:32], 32'd3);
        mem_ready = 1;
        chk("t4_memv0", 32'(mem_valid), 32'd1);
        chk("t4_addr0", 32'(mem_addr), 32'h100);
        tick();
        chk("t4_memv1", 32'(mem_valid), 32'd1);
        chk("t4_addr1", 32'(mem_addr), 32'h101);
        tick(); tick();
        chk("t4_nodrain", 32'(mem_valid), 32'd0);
        chk("t4_notempty", 32'(empty), 32'd0);

        // Test 5: advance base to 120, then a full queue straddling the wrap
        do_reset();
        for (int b = 0; b < 15; b++) begin
            for (int k = 0; k < 8; k++) st(b*8 + k, 30'h100, 32'(k), 4'hF);
            cur_sqN = W'(b*8 + 8); mem_ready = 1;
            wait_empty("t5_pre_empty");
            mem_ready = 0;
        end
        chk("t5_max_wrap", 32'(max_sqN), 32'd7);
        for (int k = 0; k < 16; k++) st(120 + k, 30'h200 + 30'(k), 32'(k), 4'hF);
        chk("t5_full", 32'(empty), 32'd0);
        cur_sqN = 8;
        tick();
        for (int r = 0; r < 5; r++) begin
            chk("t5_hold_v", 32'(mem_valid), 32'd1);
            chk("t5_hold_a", 32'(mem_addr), 32'h200);
            tick();
        end
        mem_ready = 1;
        for (int k = 0; k < 16; k++) begin
            chk("t5_pop_v", 32'(mem_valid), 32'd1);
            chk("t5_pop_a", 32'(mem_addr), 32'h200 + 32'(k));
            chk("t5_pop_d", mem_data, 32'(k));
            tick();
        end
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_memv", 32'(mem_valid), 32'd0);
        chk("t5_max", 32'(max_sqN), 32'd23);

        // Test 6: reset during a pending drain
        do_reset();
        st(0, 30'h300, 32'h5, 4'hF);
        cur_sqN = 1;
        tick();
        chk("t6_pending", 32'(mem_valid), 32'd1);
        rst = 1;
        #1;
        chk("t6_memv", 32'(mem_valid), 32'd0);
        chk("t6_max", 32'(max_sqN), 32'd15);
        chk("t6_empty", 32'(empty), 32'd1);
        idle();
        tick();
        rst = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
